// File: rtl/regfile_pkg.sv
// Shared sizes and lookup bundle for the architectural register file.
package regfile_pkg;
    localparam int REG_NUM = 32;
    localparam int NAME_W  = 5;
    localparam int NICK_W  = 5;
    localparam int DATA_W  = 32;

    localparam logic [NICK_W-1:0] ZERO_NICK = '0;

    typedef struct packed {
        logic [DATA_W-1:0] dt;
        logic [NICK_W-1:0] nick;
    } src_t;
endpackage

// File: rtl/regfile.sv
// Architectural register file with ROB rename tags and commit bypass.
import regfile_pkg::*;

module regfile (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [NAME_W-1:0] iROB_nick_regnm,
    input  logic              iROB_en,
    input  logic [NAME_W-1:0] iROB_rd_regnm,
    input  logic [DATA_W-1:0] iROB_rd_dt,
    input  logic [NICK_W-1:0] iROB_rd_nick,
    input  logic [NAME_W-1:0] iDP_rs1_regnm,
    input  logic [NAME_W-1:0] iDP_rs2_regnm,
    output logic [DATA_W-1:0] oDP_rs1_dt,
    output logic [NICK_W-1:0] oDP_rs1_nick,
    output logic [DATA_W-1:0] oDP_rs2_dt,
    output logic [NICK_W-1:0] oDP_rs2_nick
);

    logic [DATA_W-1:0] dt_mem   [REG_NUM];
    logic [NICK_W-1:0] nick_mem [REG_NUM];

    logic commit_ok;
    logic rename_ok;
    src_t rs1;
    src_t rs2;

    assign commit_ok = iROB_en && (iROB_rd_regnm != '0);
    assign rename_ok = iROB_nick_en && (iROB_nick_regnm != '0);

    // Bypass only while the register file is actually taking the commit.
    function automatic src_t lookup(input logic [NAME_W-1:0] regnm);
        src_t r;
        if (rst || regnm == '0) begin
            r.dt   = '0;
            r.nick = ZERO_NICK;
        end else if (rdy && iROB_en && iROB_rd_regnm == regnm &&
                     iROB_rd_nick == nick_mem[regnm]) begin
            r.dt   = iROB_rd_dt;
            r.nick = ZERO_NICK;
        end else begin
            r.dt   = dt_mem[regnm];
            r.nick = nick_mem[regnm];
        end
        return r;
    endfunction

    always_comb begin
        rs1 = lookup(iDP_rs1_regnm);
        rs2 = lookup(iDP_rs2_regnm);
    end

    assign oDP_rs1_dt   = rs1.dt;
    assign oDP_rs1_nick = rs1.nick;
    assign oDP_rs2_dt   = rs2.dt;
    assign oDP_rs2_nick = rs2.nick;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                dt_mem[i]   <= '0;
                nick_mem[i] <= ZERO_NICK;
            end
        end else if (rdy) begin
            if (commit_ok)
                dt_mem[iROB_rd_regnm] <= iROB_rd_dt;
            // Rename beats a same-cycle tag clear; flush beats both.
            for (int i = 1; i < REG_NUM; i++) begin
                if (iclr)
                    nick_mem[i] <= ZERO_NICK;
                else if (rename_ok && iROB_nick_regnm == NAME_W'(i))
                    nick_mem[i] <= iROB_nick;
                else if (commit_ok && iROB_rd_regnm == NAME_W'(i) &&
                         nick_mem[i] == iROB_rd_nick)
                    nick_mem[i] <= ZERO_NICK;
            end
        end
    end

endmodule
